// File: rtl/gfx256_pixel_reader_if.sv
// Read-port bundle between the pixel reader and the 256-bit wishbone master.
// The reader uses the master modport; the memory side (or a bench) uses slave.
interface gfx256_pixel_reader_if;
  logic [31:5]  read_addr_o;
  logic [31:0]  read_sel_o;
  logic         read_o;
  logic         ack_i;
  logic [255:0] dat_i;

  modport master (
    output read_addr_o,
    output read_sel_o,
    output read_o,
    input  ack_i,
    input  dat_i
  );

  modport slave (
    input  read_addr_o,
    input  read_sel_o,
    input  read_o,
    output ack_i,
    output dat_i
  );
endinterface

// File: rtl/gfx256_pixel_reader.sv
// Pixel reader: maps (x,y) to a 32-byte line and lane, reads the line, returns the pixel.
// Define GFX256_READER_LINE_CACHE_EN to add a one-line read cache.
module gfx256_pixel_reader #(
  parameter int point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:5]            target_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [point_width-1:0] target_size_y_i,
  input  logic [1:0]             color_depth_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic                   read_i,
  output logic                   ack_o,
  output logic [31:0]            color_o,
  input  logic                   invalidate_i,
  gfx256_pixel_reader_if.master  wbm
);

  typedef enum logic [2:0] {
    IDLE,
    CALC1,
    CALC2,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [31:5]            base_q, base_d;
  logic [point_width-1:0] sizeX_q, sizeX_d;
  logic [point_width-1:0] sizeY_q, sizeY_d;
  logic [1:0]             depth_q, depth_d;
  logic [point_width-1:0] pixX_q, pixX_d;
  logic [point_width-1:0] pixY_q, pixY_d;
  logic [31:0]            idx_q, idx_d;
  logic                   oob_q, oob_d;
  logic [4:0]             lane_q, lane_d;
  logic [31:5]            addr_q, addr_d;
  logic [31:0]            sel_q, sel_d;
  logic [255:0]           data_q, data_d;
  logic [31:0]            color_q, color_d;
  logic                   ackOut_q, ackOut_d;

  logic [1:0]             shiftAmt;
  logic [31:0]            byteAddr;
  logic                   cacheHit;

  // Byte enables for the whole pixel; lane low bits are ignored for wide depths.
  function automatic logic [31:0] laneSel(input logic [4:0] lane, input logic [1:0] depth);
    case (depth)
      2'b00:   laneSel = 32'h0000_0001 << lane;
      2'b01:   laneSel = 32'h0000_0003 << {lane[4:1], 1'b0};
      default: laneSel = 32'h0000_000F << {lane[4:2], 2'b00};
    endcase
  endfunction

  function automatic logic [31:0] extractPixel(input logic [255:0] line, input logic [4:0] lane,
                                               input logic [1:0] depth);
    logic [255:0] shifted;
    case (depth)
      2'b00: begin
        shifted      = line >> {lane, 3'b000};
        extractPixel = {24'h000000, shifted[7:0]};
      end
      2'b01: begin
        shifted      = line >> {lane[4:1], 4'b0000};
        extractPixel = {16'h0000, shifted[15:0]};
      end
      default: begin
        shifted      = line >> {lane[4:2], 5'b00000};
        extractPixel = shifted[31:0];
      end
    endcase
  endfunction

  assign shiftAmt = (depth_q == 2'b00) ? 2'd0 : ((depth_q == 2'b01) ? 2'd1 : 2'd2);
  assign byteAddr = {base_q, 5'b00000} + (idx_q << shiftAmt);

`ifdef GFX256_READER_LINE_CACHE_EN
  // data_q doubles as the cached line; tag/valid say whether it is reusable.
  logic [31:5] tag_q, tag_d;
  logic        valid_q, valid_d;

  assign cacheHit = valid_q & ~invalidate_i & (tag_q == byteAddr[31:5]);
`else
  logic unused_invalidate;

  assign cacheHit          = 1'b0;
  assign unused_invalidate = invalidate_i;
`endif

  assign wbm.read_o      = (state_q == REQ);
  assign wbm.read_addr_o = addr_q;
  assign wbm.read_sel_o  = sel_q;
  assign ack_o           = ackOut_q;
  assign color_o         = color_q;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    sizeX_d  = sizeX_q;
    sizeY_d  = sizeY_q;
    depth_d  = depth_q;
    pixX_d   = pixX_q;
    pixY_d   = pixY_q;
    idx_d    = idx_q;
    oob_d    = oob_q;
    lane_d   = lane_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    data_d   = data_q;
    color_d  = color_q;
    ackOut_d = 1'b0;
`ifdef GFX256_READER_LINE_CACHE_EN
    tag_d    = tag_q;
    valid_d  = valid_q;
`endif

    case (state_q)
      IDLE: begin
        if (read_i) begin
          base_d  = target_base_i;
          sizeX_d = target_size_x_i;
          sizeY_d = target_size_y_i;
          depth_d = color_depth_i;
          pixX_d  = pixel_x_i;
          pixY_d  = pixel_y_i;
          state_d = CALC1;
        end
      end

      CALC1: begin
        idx_d   = 32'(pixY_q) * 32'(sizeX_q) + 32'(pixX_q);
        oob_d   = (pixX_q >= sizeX_q) | (pixY_q >= sizeY_q);
        state_d = CALC2;
      end

      CALC2: begin
        lane_d = byteAddr[4:0];
        if (oob_q || cacheHit) begin
          state_d = DONE;
        end else begin
          addr_d  = byteAddr[31:5];
          sel_d   = laneSel(byteAddr[4:0], depth_q);
          state_d = REQ;
        end
      end

      REQ, WAIT: begin
        if (wbm.ack_i) begin
          data_d  = wbm.dat_i;
          state_d = DONE;
`ifdef GFX256_READER_LINE_CACHE_EN
          tag_d   = addr_q;
          valid_d = 1'b1;
`endif
        end else begin
          state_d = WAIT;
        end
      end

      DONE: begin
        ackOut_d = 1'b1;
        color_d  = oob_q ? 32'h0 : extractPixel(data_q, lane_q, depth_q);
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef GFX256_READER_LINE_CACHE_EN
    // Invalidate wins over a fill landing in the same cycle.
    if (invalidate_i) begin
      valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      base_q   <= '0;
      sizeX_q  <= '0;
      sizeY_q  <= '0;
      depth_q  <= '0;
      pixX_q   <= '0;
      pixY_q   <= '0;
      idx_q    <= '0;
      oob_q    <= 1'b0;
      lane_q   <= '0;
      addr_q   <= '0;
      sel_q    <= '0;
      data_q   <= '0;
      color_q  <= '0;
      ackOut_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      sizeX_q  <= sizeX_d;
      sizeY_q  <= sizeY_d;
      depth_q  <= depth_d;
      pixX_q   <= pixX_d;
      pixY_q   <= pixY_d;
      idx_q    <= idx_d;
      oob_q    <= oob_d;
      lane_q   <= lane_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      color_q  <= color_d;
      ackOut_q <= ackOut_d;
    end
  end

`ifdef GFX256_READER_LINE_CACHE_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_gfx256_pixel_reader.sv
// Scoreboard bench for gfx256_pixel_reader: directed pixel reads against a
// responding wishbone model, with separate colour monitor and read checker.
module tb_gfx256_pixel_reader;

  localparam logic [255:0] PATTERN = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [255:0] BYTE3A5 = 256'hA5000000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:5] target_base_i;
  logic [15:0] target_size_x_i;
  logic [15:0] target_size_y_i;
  logic [1:0]  color_depth_i;
  logic [15:0] pixel_x_i;
  logic [15:0] pixel_y_i;
  logic        read_i;
  logic        ack_o;
  logic [31:0] color_o;
  logic        invalidate_i;

  gfx256_pixel_reader_if wbm ();

  gfx256_pixel_reader #(.point_width(16)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .target_base_i   (target_base_i),
    .target_size_x_i (target_size_x_i),
    .target_size_y_i (target_size_y_i),
    .color_depth_i   (color_depth_i),
    .pixel_x_i       (pixel_x_i),
    .pixel_y_i       (pixel_y_i),
    .read_i          (read_i),
    .ack_o           (ack_o),
    .color_o         (color_o),
    .invalidate_i    (invalidate_i),
    .wbm             (wbm)
  );

  always #5 clk_i = ~clk_i;

  int testsRun  = 0;
  int failCount = 0;

  logic [31:0] expColorQ[$];
  logic [31:0] expAddrQ[$];
  logic [31:0] expSelQ[$];

  logic [255:0] respData  = '0;
  int           respDelay = 0;
  logic         respBusy  = 1'b0;
  logic         skipHold  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Colour scoreboard: every ack_o pulse must match the oldest expected colour.
  initial begin
    logic [31:0] expColor;
    forever begin
      @(negedge clk_i);
      if (ack_o === 1'b1) begin
        if (expColorQ.size() == 0) begin
          checkOutput("unexpectedAck", 32'd1, 32'd0);
        end else begin
          expColor = expColorQ.pop_front();
          checkOutput("color", color_o, expColor);
        end
      end
    end
  end

  // Wishbone responder: checks each read strobe, holds off, then returns respData.
  initial begin
    logic [31:0] reqAddr;
    logic [31:0] reqSel;
    wbm.ack_i = 1'b0;
    wbm.dat_i = '0;
    forever begin
      @(negedge clk_i);
      if (wbm.read_o === 1'b1) begin
        respBusy = 1'b1;
        reqAddr  = 32'(wbm.read_addr_o);
        reqSel   = wbm.read_sel_o;
        if (expAddrQ.size() == 0) begin
          checkOutput("unexpectedRead", 32'd1, 32'd0);
        end else begin
          checkOutput("readAddr", reqAddr, expAddrQ.pop_front());
          checkOutput("readSel", reqSel, expSelQ.pop_front());
        end
        for (int d = 0; d < respDelay; d++) begin
          @(negedge clk_i);
          checkOutput("readPulse", 32'(wbm.read_o), 32'd0);
          if (!skipHold) begin
            checkOutput("addrHeld", 32'(wbm.read_addr_o), reqAddr);
            checkOutput("selHeld", wbm.read_sel_o, reqSel);
          end
        end
        wbm.ack_i = 1'b1;
        wbm.dat_i = respData;
        @(negedge clk_i);
        wbm.ack_i = 1'b0;
        respBusy  = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input int x, input int y, input logic [1:0] depth, input logic inv,
                               input logic expRead, input logic [31:0] expAddr,
                               input logic [31:0] expSel, input logic [31:0] expColor,
                               input int expLat);
    int   lat;
    logic got;
    logic [31:0] heldColor;
    if (inv) begin
      @(negedge clk_i);
      invalidate_i = 1'b1;
      @(negedge clk_i);
      invalidate_i = 1'b0;
    end
    if (expRead) begin
      expAddrQ.push_back(expAddr);
      expSelQ.push_back(expSel);
    end
    expColorQ.push_back(expColor);
    @(negedge clk_i);
    color_depth_i = depth;
    pixel_x_i     = 16'(x);
    pixel_y_i     = 16'(y);
    read_i        = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    read_i = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk_i);
      if (ack_o === 1'b1) begin
        got = 1'b1;
        lat = k;
      end
    end
    if (!got) begin
      checkOutput("ackTimeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", 32'(lat), 32'(expLat));
      heldColor = color_o;
      @(negedge clk_i);
      checkOutput("ackPulse", 32'(ack_o), 32'd0);
      checkOutput("colorHeld", color_o, heldColor);
    end
    while (respBusy) @(negedge clk_i);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    rst_i           = 1'b1;
    read_i          = 1'b0;
    invalidate_i    = 1'b0;
    target_base_i   = 27'h8;
    target_size_x_i = 16'd64;
    target_size_y_i = 16'd64;
    color_depth_i   = 2'b00;
    pixel_x_i       = '0;
    pixel_y_i       = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    $display("[TB] reset state");
    checkOutput("rstReadO", 32'(wbm.read_o), 32'd0);
    checkOutput("rstAckO", 32'(ack_o), 32'd0);
    checkOutput("rstColor", color_o, 32'd0);
    checkOutput("rstAddr", 32'(wbm.read_addr_o), 32'd0);
    checkOutput("rstSel", wbm.read_sel_o, 32'd0);

    $display("[TB] in-bounds reads at 8/16/32 bpp");
    respData = BYTE3A5;
    applyStimulus(3, 2, 2'b00, 1'b1, 1'b1, 32'h0C, 32'h0000_0008, 32'h0000_00A5, 4);
    respData = PATTERN;
    applyStimulus(17, 0, 2'b01, 1'b1, 1'b1, 32'h09, 32'h0000_000C, 32'h0000_0302, 4);
    applyStimulus(7, 0, 2'b10, 1'b1, 1'b1, 32'h08, 32'hF000_0000, 32'h1F1E_1D1C, 4);

    $display("[TB] out-of-bounds reads");
    applyStimulus(64, 0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3);
    applyStimulus(17, 0, 2'b01, 1'b1, 1'b1, 32'h09, 32'h0000_000C, 32'h0000_0302, 4);
    applyStimulus(0, 64, 2'b11, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3);

    $display("[TB] delayed ack");
    respDelay = 5;
    applyStimulus(5, 0, 2'b00, 1'b1, 1'b1, 32'h08, 32'h0000_0020, 32'h0000_0005, 9);
    respDelay = 0;

    $display("[TB] reset while waiting");
    respDelay = 8;
    skipHold  = 1'b1;
    expAddrQ.push_back(32'h0C);
    expSelQ.push_back(32'h0000_0008);
    @(negedge clk_i);
    color_depth_i = 2'b00;
    pixel_x_i     = 16'd3;
    pixel_y_i     = 16'd2;
    read_i        = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    read_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("midRstReadO", 32'(wbm.read_o), 32'd0);
    checkOutput("midRstAckO", 32'(ack_o), 32'd0);
    checkOutput("midRstColor", color_o, 32'd0);
    checkOutput("midRstAddr", 32'(wbm.read_addr_o), 32'd0);
    checkOutput("midRstSel", wbm.read_sel_o, 32'd0);
    guard = 0;
    while (respBusy && guard < 40) begin
      @(negedge clk_i);
      guard++;
    end
    checkOutput("respDrain", 32'(respBusy), 32'd0);
    repeat (4) @(negedge clk_i);
    respDelay = 0;
    skipHold  = 1'b0;

    $display("[TB] request after reset");
    respData = BYTE3A5;
    applyStimulus(3, 2, 2'b00, 1'b1, 1'b1, 32'h0C, 32'h0000_0008, 32'h0000_00A5, 4);

    $display("[TB] same-line reuse and invalidate");
    respData = PATTERN;
    applyStimulus(3, 2, 2'b00, 1'b1, 1'b1, 32'h0C, 32'h0000_0008, 32'h0000_0003, 4);
`ifdef GFX256_READER_LINE_CACHE_EN
    applyStimulus(4, 2, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0004, 3);
`else
    applyStimulus(4, 2, 2'b00, 1'b0, 1'b1, 32'h0C, 32'h0000_0010, 32'h0000_0004, 4);
`endif
    applyStimulus(5, 2, 2'b00, 1'b1, 1'b1, 32'h0C, 32'h0000_0020, 32'h0000_0005, 4);

    repeat (5) @(negedge clk_i);
    checkOutput("pendingColors", 32'(expColorQ.size()), 32'd0);
    checkOutput("pendingReads", 32'(expAddrQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
